// File: rtl/key_bounce_gen.sv
// key_bounce_gen -- mechanical key emulator for exercising debouncers.
//
// When a press request is accepted, key_o plays out three phases:
//   1. A bounce burst of 2*BOUNCE_CNT segments (1,0,1,0,...).
//   2. A stable high hold of HOLD_TICKS cycles.
//   3. Optionally, a release burst of 2*BOUNCE_CNT segments (0,1,0,1,...).
// The sequence ends with key_o low and a one-cycle done strobe.
//
// Every segment lasts L cycles. L comes from glitch_len_i, which is latched
// when the request is accepted; values above GLITCH_TICKS_MAX are clamped
// to GLITCH_TICKS_MAX. A value of 0 selects LFSR-random segment lengths.
//
// Optional feature macro: KEY_BOUNCE_RELEASE_EN
//   defined   - the release burst (phase 3) is generated.
//   undefined - key_o falls cleanly right after the hold.
//
// Ports
//   clk_i        clock
//   srst_i       synchronous reset, active-high
//   req_i        press request, accepted only while ready_o=1
//   glitch_len_i fixed segment length, 0 = random
//   ready_o      idle, a request can be accepted
//   key_o        raw key line, 1 = pressed (registered)
//   done_stb_o   one-cycle strobe: sequence finished, key_o is low
module key_bounce_gen #(
  parameter int          BOUNCE_CNT       = 2,
  parameter int          GLITCH_TICKS_MAX = 4,
  parameter int          HOLD_TICKS       = 10,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                              clk_i,
  input  logic                              srst_i,
  input  logic                              req_i,
  input  logic [$clog2(GLITCH_TICKS_MAX):0] glitch_len_i,
  output logic                              ready_o,
  output logic                              key_o,
  output logic                              done_stb_o
);

  localparam int LW   = $clog2(GLITCH_TICKS_MAX);
  localparam int GLW  = LW + 1;
  localparam int SEGS = 2 * BOUNCE_CNT;
  localparam int LAST = (SEGS > 0) ? SEGS - 1 : 0;
  localparam int SW   = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int CMAX = (HOLD_TICKS > GLITCH_TICKS_MAX) ?
                        ((HOLD_TICKS > SEGS) ? HOLD_TICKS : SEGS) :
                        ((GLITCH_TICKS_MAX > SEGS) ? GLITCH_TICKS_MAX : SEGS);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_TICKS - 1);
  localparam logic [SW-1:0] SEG_END = SW'(LAST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef KEY_BOUNCE_RELEASE_EN
  localparam logic [1:0] S_REL   = 2'd3;
`endif

  logic [1:0]     state;
  logic [CW-1:0]  cnt;      // cycles remaining in the current segment, minus one
  logic [SW-1:0]  seg;      // segment index within a bounce burst
  logic [GLW-1:0] glen_q;
  logic [15:0]    lfsr;
  logic [15:0]    lfsr_nxt;

  // Fibonacci LFSR, taps for x^16+x^14+x^13+x^11+1
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Segment length minus one, ready to load into cnt
  function automatic logic [CW-1:0] seg_m1(input logic [GLW-1:0] g,
                                           input logic [LW-1:0]  rnd);
    if (g == '0)
      seg_m1 = CW'(rnd);
    else if (g > GLW'(GLITCH_TICKS_MAX))
      seg_m1 = CW'(GLITCH_TICKS_MAX - 1);
    else
      seg_m1 = CW'(g) - CW'(1);
  endfunction

  assign ready_o = (state == S_IDLE);

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= S_IDLE;
      key_o      <= 1'b0;
      done_stb_o <= 1'b0;
      lfsr       <= LFSR_SEED;
      cnt        <= '0;
      seg        <= '0;
      glen_q     <= '0;
    end else begin
      done_stb_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            glen_q <= glitch_len_i;
            key_o  <= 1'b1;
            if (SEGS > 0) begin
              // The first segment is sized from the live input, because glen_q is only being loaded now.
              state <= S_PRESS;
              seg   <= '0;
              cnt   <= seg_m1(glitch_len_i, lfsr[LW-1:0]);
              lfsr  <= lfsr_nxt;
            end else begin
              state <= S_HOLD;
              cnt   <= HOLD_M1;
            end
          end
        end
        S_PRESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (seg == SEG_END) begin
            state <= S_HOLD;
            key_o <= 1'b1;
            cnt   <= HOLD_M1;
          end else begin
            seg   <= seg + SW'(1);
            key_o <= ~key_o;
            cnt   <= seg_m1(glen_q, lfsr[LW-1:0]);
            lfsr  <= lfsr_nxt;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
`ifdef KEY_BOUNCE_RELEASE_EN
            if (SEGS > 0) begin
              state <= S_REL;
              seg   <= '0;
              key_o <= 1'b0;
              cnt   <= seg_m1(glen_q, lfsr[LW-1:0]);
              lfsr  <= lfsr_nxt;
            end else begin
              state      <= S_IDLE;
              key_o      <= 1'b0;
              done_stb_o <= 1'b1;
            end
`else
            state      <= S_IDLE;
            key_o      <= 1'b0;
            done_stb_o <= 1'b1;
`endif
          end
        end
`ifdef KEY_BOUNCE_RELEASE_EN
        S_REL: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (seg == SEG_END) begin
            state      <= S_IDLE;
            key_o      <= 1'b0;
            done_stb_o <= 1'b1;
          end else begin
            seg   <= seg + SW'(1);
            key_o <= ~key_o;
            cnt   <= seg_m1(glen_q, lfsr[LW-1:0]);
            lfsr  <= lfsr_nxt;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen.
//   u1: BOUNCE_CNT=2, HOLD_TICKS=10
//   u0: BOUNCE_CNT=0, HOLD_TICKS=5
// Both instances share one stimulus stream.
//
// Each cycle the driver pops the expected {ready, key, done} triple for
// that cycle from a per-instance waveform model, and pushes it onto a
// scoreboard queue. The monitor pops the scoreboard on the falling edge and
// compares it against the DUT outputs.
module tb_key_bounce_gen;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef KEY_BOUNCE_RELEASE_EN
  localparam int EXP_EDGES = 10;
`else
  localparam int EXP_EDGES = 6;
`endif

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       req = 1'b0;
  logic [2:0] glen = 3'd0;
  logic       rdy0, key0, dn0, rdy1, key1, dn1;

  always #5 clk = ~clk;

  key_bounce_gen #(.BOUNCE_CNT(0), .GLITCH_TICKS_MAX(4), .HOLD_TICKS(5), .LFSR_SEED(SEED)) u0 (
    .clk_i(clk), .srst_i(srst), .req_i(req), .glitch_len_i(glen),
    .ready_o(rdy0), .key_o(key0), .done_stb_o(dn0));
  key_bounce_gen #(.BOUNCE_CNT(2), .GLITCH_TICKS_MAX(4), .HOLD_TICKS(10), .LFSR_SEED(SEED)) u1 (
    .clk_i(clk), .srst_i(srst), .req_i(req), .glitch_len_i(glen),
    .ready_o(rdy1), .key_o(key1), .done_stb_o(dn1));

  int n_cmp = 0;
  int n_err = 0;
  int n_seq = 0;
  int ecnt  = 0;
  logic kprev   = 1'b0;
  logic edge_en = 1'b0;

  logic [2:0]  wave0[$], wave1[$], sb0[$], sb1[$];
  logic [15:0] lf[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic push_w(input int id, input logic [2:0] v);
    if (id == 0) wave0.push_back(v);
    else         wave1.push_back(v);
  endtask

  task automatic pop_w(input int id, output logic [2:0] v);
    v = 3'b100;  // idle: ready=1, key=0, done=0
    if (id == 0) begin
      if (wave0.size() > 0) v = wave0.pop_front();
    end else begin
      if (wave1.size() > 0) v = wave1.pop_front();
    end
  endtask

  task automatic seg_len(input int id, input logic [2:0] g, output int l);
    if (g != 3'd0) l = (g > 3'd4) ? 4 : int'(g);
    else           l = int'(lf[id][1:0]) + 1;
    lf[id] = lfsr_step(lf[id]);
  endtask

  // Expected outputs for the cycles following an accepted request.
  task automatic gen_seq(input int id, input logic [2:0] g);
    int b, h, l;
    b = (id == 1) ? 2 : 0;
    h = (id == 1) ? 10 : 5;
    for (int s = 0; s < 2 * b; s++) begin
      seg_len(id, g, l);
      repeat (l) push_w(id, {1'b0, (s % 2 == 0), 1'b0});
    end
    repeat (h) push_w(id, 3'b010);
`ifdef KEY_BOUNCE_RELEASE_EN
    for (int s = 0; s < 2 * b; s++) begin
      seg_len(id, g, l);
      repeat (l) push_w(id, {1'b0, (s % 2 == 1), 1'b0});
    end
`endif
    push_w(id, 3'b101);
  endtask

  task automatic tick(input logic r, input logic [2:0] g, input logic s);
    logic [2:0] e;
    @(posedge clk); #1;
    req = r; glen = g; srst = s;
    for (int id = 0; id < 2; id++) begin
      pop_w(id, e);
      if (id == 0) sb0.push_back(e);
      else         sb1.push_back(e);
      if (!s && r && e[2]) begin
        gen_seq(id, g);
        if (id == 1) n_seq++;
      end
    end
    if (s) begin
      wave0.delete(); wave1.delete();
      lf[0] = SEED; lf[1] = SEED;
    end
  endtask

  always @(negedge clk) begin
    if (sb0.size() > 0) chk("u0_out", {29'd0, rdy0, key0, dn0}, {29'd0, sb0.pop_front()});
    if (sb1.size() > 0) chk("u1_out", {29'd0, rdy1, key1, dn1}, {29'd0, sb1.pop_front()});
    if (edge_en) begin
      if (key1 !== kprev) ecnt++;
      kprev = key1;
      if (dn1) begin
        chk("u1_edges", ecnt, EXP_EDGES);
        ecnt = 0;
      end
    end
  end

  initial begin
    lf[0] = SEED; lf[1] = SEED;
    repeat (3) @(posedge clk);
    // idle after reset
    repeat (20) tick(0, 3'd0, 0);
    // fixed L=3; glen changes and stray requests while busy
    tick(1, 3'd3, 0);
    for (int c = 0; c < 40; c++) tick(c == 5 || c == 20, (c < 10) ? 3'd1 : 3'd5, 0);
    repeat (10) tick(0, 3'd0, 0);
    // clamp: 7 -> 4
    tick(1, 3'd7, 0);
    repeat (50) tick(0, 3'd0, 0);
    // request held high: accepted in each done cycle
    repeat (60) tick(1, 3'd2, 0);
    repeat (50) tick(0, 3'd0, 0);
    // random lengths, 200 back-to-back sequences on u1
    ecnt = 0; kprev = 1'b0; edge_en = 1'b1; n_seq = 0;
    for (int c = 0; c < 20000 && n_seq < 200; c++) tick(1, 3'd0, 0);
    repeat (60) tick(0, 3'd0, 0);
    edge_en = 1'b0;
    chk("seq_count", n_seq, 200);
    // reset at cycle 8 of a fixed sequence
    tick(1, 3'd3, 0);
    repeat (7) tick(0, 3'd3, 0);
    tick(0, 3'd3, 1);
    repeat (5) tick(0, 3'd0, 0);
    // random mode: full run, reset, aborted run, reset; twice for reproducibility
    repeat (2) begin
      tick(1, 3'd0, 0);
      repeat (60) tick(0, 3'd0, 0);
      tick(0, 3'd0, 1);
      tick(0, 3'd0, 0);
      tick(1, 3'd0, 0);
      repeat (7) tick(0, 3'd0, 0);
      tick(0, 3'd0, 1);
      repeat (3) tick(0, 3'd0, 0);
    end
    repeat (5) tick(0, 3'd0, 0);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
